// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master drives start and operands; the slave returns status and product.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             overflow;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, result, result_hi, overflow
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, result, result_hi, overflow
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-4 Booth multiplier retiring two product bits per cycle; start-to-done WIDTH/2+1 edges.
// start is ignored while busy; results are registered and held until the next completion.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  booth_mult_seq_if.slave bus
);
  localparam int EW = WIDTH + 2;      // extended operand width
  localparam int UW = WIDTH + 4;      // accumulator upper part, holds +-2M without wrap
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [UW-1:0]     acc_hi;
  logic [EW-1:0]     acc_lo;
  logic              acc_q;
  logic [EW-1:0]     mcand;
  logic              sgn_q;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic              last;
  logic [2:0]        win;
  logic [UW-1:0]     m_ext;
  logic [UW-1:0]     mag;
  logic              neg;
  logic [UW-1:0]     sum;
  logic [UW-1:0]     hi_nxt;
  logic [EW-1:0]     lo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic              ovf;

  assign accept = (state != RUN) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  assign win   = {acc_lo[1], acc_lo[0], acc_q};
  assign m_ext = {{(UW-EW){mcand[EW-1]}}, mcand};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (win)
      3'b001, 3'b010: mag = m_ext;
      3'b011:         mag = m_ext << 1;
      3'b100: begin mag = m_ext << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = m_ext; neg = 1'b1; end
      default:        mag = '0;
    endcase
  end

  // Subtraction as one's complement plus carry-in
  assign sum    = acc_hi + (neg ? ~mag : mag) + UW'(neg);
  assign hi_nxt = {{2{sum[UW-1]}}, sum[UW-1:2]};
  assign lo_nxt = {sum[1:0], acc_lo[EW-1:2]};
  assign prod   = {hi_nxt[WIDTH-3:0], lo_nxt};
  assign ovf    = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (prod[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi        <= '0;
      acc_lo        <= '0;
      acc_q         <= 1'b0;
      mcand         <= '0;
      sgn_q         <= 1'b0;
      cnt           <= '0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.overflow  <= 1'b0;
    end else if (accept) begin
      mcand  <= {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      acc_lo <= {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
      acc_hi <= '0;
      acc_q  <= 1'b0;
      sgn_q  <= bus.is_signed;
      cnt    <= CW'(N);
    end else if (state == RUN) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      acc_q  <= acc_lo[1];
      cnt    <= cnt - CW'(1);
      if (last) begin
        bus.result    <= prod[WIDTH-1:0];
        bus.result_hi <= prod[2*WIDTH-1:WIDTH];
        bus.overflow  <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: directed and random products on 32-, 16- and 8-bit instances
// against an arithmetic reference model, plus handshake, back-to-back and reset checks.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(32)) b32();
  booth_mult_seq_if #(.WIDTH(16)) b16();
  booth_mult_seq_if #(.WIDTH(8))  b8();

  booth_mult_seq #(.WIDTH(32)) u32 (.clk(clk), .reset(rst), .bus(b32));
  booth_mult_seq #(.WIDTH(16)) u16 (.clk(clk), .reset(rst), .bus(b16));
  booth_mult_seq #(.WIDTH(8))  u8  (.clk(clk), .reset(rst), .bus(b8));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact product of the two w-bit operands as integers, then reduced to fields.
  function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi, output bit ov);
    logic signed [65:0] ea, eb, p, lim;
    logic [65:0] m;
    ea = $signed({34'b0, a});
    eb = $signed({34'b0, b});
    if (sgn && a[w-1]) ea = ea - (66'sd1 <<< w);
    if (sgn && b[w-1]) eb = eb - (66'sd1 <<< w);
    p   = ea * eb;
    m   = (66'd1 << w) - 66'd1;
    lo  = 32'(p & m);
    hi  = 32'((p >>> w) & m);
    lim = 66'sd1 <<< (w - 1);
    ov  = sgn ? ((p < -lim) || (p >= lim)) : (p >= (66'sd1 <<< w));
  endfunction

  task automatic start32(input bit s, input logic [31:0] a, input logic [31:0] b);
    b32.start = 1'b1; b32.is_signed = s; b32.multiplicand = a; b32.multiplier = b;
    @(posedge clk); #1 b32.start = 1'b0;
  endtask

  task automatic wait32(input string tag, input bit disturb, input logic [31:0] elo,
                        input logic [31:0] ehi, input bit eov);
    int lat = 0, nb = 0, both = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (b32.busy) nb++;
      if (b32.busy && b32.done) both++;
      if (b32.done) begin
        b32.start = 1'b0;
        break;
      end
      if (disturb) begin
        b32.start = 1'($urandom); b32.is_signed = 1'($urandom);
        b32.multiplicand = $urandom; b32.multiplier = $urandom;
      end
    end
    chk({tag, "_lat"}, 64'(lat - 1), 64'd17);
    chk({tag, "_busy"}, 64'(nb), 64'd17);
    chk({tag, "_overlap"}, 64'(both), 64'd0);
    chk({tag, "_lo"}, 64'(b32.result), 64'(elo));
    chk({tag, "_hi"}, 64'(b32.result_hi), 64'(ehi));
    chk({tag, "_ov"}, 64'(b32.overflow), 64'(eov));
  endtask

  task automatic op16(input bit s, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] elo, ehi; bit eov; int lat = 0;
    model(16, s, {16'b0, a}, {16'b0, b}, elo, ehi, eov);
    @(negedge clk);
    b16.start = 1'b1; b16.is_signed = s; b16.multiplicand = a; b16.multiplier = b;
    @(posedge clk); #1 b16.start = 1'b0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (b16.done) break;
    end
    chk("w16_lat", 64'(lat - 1), 64'd9);
    chk("w16_prod", 64'({b16.overflow, b16.result_hi, b16.result}),
        64'({eov, ehi[15:0], elo[15:0]}));
  endtask

  task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] elo, ehi; bit eov; int lat = 0;
    model(8, s, {24'b0, a}, {24'b0, b}, elo, ehi, eov);
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = s; b8.multiplicand = a; b8.multiplier = b;
    @(posedge clk); #1 b8.start = 1'b0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (b8.done) break;
    end
    chk("w8_lat", 64'(lat - 1), 64'd5);
    chk("w8_prod", 64'({b8.overflow, b8.result_hi, b8.result}),
        64'({eov, ehi[7:0], elo[7:0]}));
  endtask

  initial begin
    logic [31:0] a, b, elo, ehi;
    bit s, eov;
    int ndone;
    b32.start = 1'b0; b32.is_signed = 1'b0; b32.multiplicand = '0; b32.multiplier = '0;
    b16.start = 1'b0; b16.is_signed = 1'b0; b16.multiplicand = '0; b16.multiplier = '0;
    b8.start  = 1'b0; b8.is_signed  = 1'b0; b8.multiplicand  = '0; b8.multiplier  = '0;

    #12;
    chk("reset_flags", 64'({b32.busy, b32.done, b32.overflow}), 64'd0);
    chk("reset_prod", {b32.result_hi, b32.result}, 64'd0);
    @(negedge clk); rst = 1'b0;

    @(negedge clk); start32(1'b1, 32'd7, 32'hFFFF_FFFD);
    wait32("s7xm3", 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk); start32(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait32("smin_sq", 1'b0, 32'h0, 32'h4000_0000, 1'b1);
    @(negedge clk); start32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32("umax_sq", 1'b0, 32'h1, 32'hFFFF_FFFE, 1'b1);
    @(negedge clk); start32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32("sm1_sq", 1'b0, 32'h1, 32'h0, 1'b0);
    @(negedge clk); start32(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait32("u2p16_sq", 1'b0, 32'h0, 32'h1, 1'b1);

    // Operands and start churn while running; result must follow the captured pair.
    @(negedge clk); start32(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait32("disturb", 1'b1, 32'hFFFF_FD44, 32'hFFFF_FFFF, 1'b0);
    // Start during the DONE cycle: accepted with no idle gap.
    start32(1'b0, 32'd3, 32'd5);
    wait32("b2b", 1'b0, 32'd15, 32'd0, 1'b0);

    @(negedge clk); start32(1'b1, 32'd5, 32'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_flags", 64'({b32.busy, b32.done, b32.overflow}), 64'd0);
    chk("midrst_prod", {b32.result_hi, b32.result}, 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (b32.done || b32.busy) ndone++;
    end
    chk("midrst_quiet", 64'(ndone), 64'd0);
    start32(1'b0, 32'd12, 32'd12);
    wait32("r12x12", 1'b0, 32'd144, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom); a = $urandom; b = $urandom;
      if (i % 4 == 1) a = 32'($signed(16'($urandom)));
      if (i % 4 == 2) b = {b[31], 31'd0};
      model(32, s, a, b, elo, ehi, eov);
      @(negedge clk); start32(s, a, b);
      wait32("rnd32", 1'b0, elo, ehi, eov);
    end

    for (int i = 0; i < 300; i++) op16(1'($urandom), 16'($urandom), 16'($urandom));
    op16(1'b1, 16'h8000, 16'h8000);
    op16(1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 400; i++) op8(1'($urandom), 8'($urandom), 8'($urandom));
    op8(1'b1, 8'h80, 8'h80);
    op8(1'b1, 8'h80, 8'h7F);
    op8(1'b0, 8'hFF, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
